// File: rtl/snake_body_array.sv
// Snake body store: shift array of segment coordinates with head at index 0,
// step-time self-collision check, combinational pixel query and registered indexed read.
module snake_body_array #(
    parameter int COORD_W  = 5,
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3,
    parameter int INIT_X   = 10,
    parameter int INIT_Y   = 10,
    parameter int LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    input  logic [COORD_W-1:0] head_x,
    input  logic [COORD_W-1:0] head_y,
    input  logic               grow,
    input  logic [COORD_W-1:0] query_x,
    input  logic [COORD_W-1:0] query_y,
    output logic               query_hit,
    output logic               query_head,
    input  logic [LEN_W-1:0]   rd_idx,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    output logic               rd_valid,
    output logic [LEN_W-1:0]   length,
    output logic               full,
    output logic               collide,
    output logic               game_over
);

    typedef enum logic {RUN, DEAD} state_t;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] seg_x_q [MAX_LEN];
    logic [COORD_W-1:0] seg_y_q [MAX_LEN];
    logic [COORD_W-1:0] seg_x_d [MAX_LEN];
    logic [COORD_W-1:0] seg_y_d [MAX_LEN];
    logic [LEN_W-1:0]   length_q, length_d;
    logic               collide_q, collide_d;
    logic               game_over_q, game_over_d;
    logic [COORD_W-1:0] rd_x_q, rd_x_d;
    logic [COORD_W-1:0] rd_y_q, rd_y_d;
    logic               rd_valid_q, rd_valid_d;
    logic               step_hit;
    int                 coll_lim;

    always_comb begin
        query_hit  = 1'b0;
        query_head = (seg_x_q[0] == query_x) && (seg_y_q[0] == query_y);
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(length_q) && seg_x_q[i] == query_x && seg_y_q[i] == query_y)
                query_hit = 1'b1;
        end
    end

    // Without growth the tail cell is vacated by this step, so it is excluded.
    always_comb begin
        step_hit = 1'b0;
        coll_lim = grow ? int'(length_q) : int'(length_q) - 1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < coll_lim && seg_x_q[i] == head_x && seg_y_q[i] == head_y)
                step_hit = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        length_d    = length_q;
        collide_d   = 1'b0;
        game_over_d = game_over_q;
        for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_d[i] = seg_x_q[i];
            seg_y_d[i] = seg_y_q[i];
        end
        if (state_q == RUN && step) begin
            if (step_hit) begin
                collide_d   = 1'b1;
                game_over_d = 1'b1;
                state_d     = DEAD;
            end else begin
                seg_x_d[0] = head_x;
                seg_y_d[0] = head_y;
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_x_d[i] = seg_x_q[i-1];
                    seg_y_d[i] = seg_y_q[i-1];
                end
                if (grow && length_q != LEN_W'(MAX_LEN))
                    length_d = length_q + 1'b1;
            end
        end
    end

    always_comb begin
        rd_valid_d = int'(rd_idx) < int'(length_q);
        rd_x_d     = '0;
        rd_y_d     = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (int'(rd_idx) == i) begin
                rd_x_d = seg_x_q[i];
                rd_y_d = seg_y_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            length_q    <= LEN_W'(INIT_LEN);
            collide_q   <= 1'b0;
            game_over_q <= 1'b0;
            rd_x_q      <= '0;
            rd_y_q      <= '0;
            rd_valid_q  <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= (i < INIT_LEN) ? COORD_W'(INIT_X - i) : '0;
                seg_y_q[i] <= (i < INIT_LEN) ? COORD_W'(INIT_Y) : '0;
            end
        end else begin
            state_q     <= state_d;
            length_q    <= length_d;
            collide_q   <= collide_d;
            game_over_q <= game_over_d;
            rd_x_q      <= rd_x_d;
            rd_y_q      <= rd_y_d;
            rd_valid_q  <= rd_valid_d;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= seg_x_d[i];
                seg_y_q[i] <= seg_y_d[i];
            end
        end
    end

    assign rd_x      = rd_x_q;
    assign rd_y      = rd_y_q;
    assign rd_valid  = rd_valid_q;
    assign length    = length_q;
    assign full      = (length_q == LEN_W'(MAX_LEN));
    assign collide   = collide_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_snake_body_array.sv
// Bench for snake_body_array: behavioural body model plus a queue of expected read-port results.
module tb_snake_body_array;

    logic       clk = 1'b0;
    logic       rst, step, grow;
    logic [4:0] head_x, head_y, query_x, query_y;
    logic [5:0] rd_idx;
    logic [2:0] rd_idx4;
    logic       query_hit, query_head, rd_valid, full, collide, game_over;
    logic [4:0] rd_x, rd_y;
    logic [5:0] length;
    logic       query_hit4, query_head4, rd_valid4, full4, collide4, game_over4;
    logic [4:0] rd_x4, rd_y4;
    logic [2:0] length4;

    snake_body_array dut (
        .clk(clk), .rst(rst), .step(step), .head_x(head_x), .head_y(head_y), .grow(grow),
        .query_x(query_x), .query_y(query_y), .query_hit(query_hit), .query_head(query_head),
        .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid),
        .length(length), .full(full), .collide(collide), .game_over(game_over));

    snake_body_array #(.MAX_LEN(4)) dut4 (
        .clk(clk), .rst(rst), .step(step), .head_x(head_x), .head_y(head_y), .grow(grow),
        .query_x(query_x), .query_y(query_y), .query_hit(query_hit4), .query_head(query_head4),
        .rd_idx(rd_idx4), .rd_x(rd_x4), .rd_y(rd_y4), .rd_valid(rd_valid4),
        .length(length4), .full(full4), .collide(collide4), .game_over(game_over4));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model of the body of whichever instance is being checked
    logic [4:0] mx[$];
    logic [4:0] my[$];
    int         mlen, mmax = 32;
    bit         mdead, mcol;

    typedef struct {bit v; logic [4:0] x; logic [4:0] y;} rd_exp_t;
    rd_exp_t sb[$];

    function automatic bit m_hit(logic [4:0] x, logic [4:0] y);
        for (int i = 0; i < mlen; i++) if (mx[i] == x && my[i] == y) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_coll(logic [4:0] x, logic [4:0] y, bit g);
        int n = g ? mlen : mlen - 1;
        for (int i = 0; i < n; i++) if (mx[i] == x && my[i] == y) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_step(logic [4:0] x, logic [4:0] y, bit g);
        mcol = 1'b0;
        if (mdead) return;
        if (m_coll(x, y, g)) begin
            mcol = 1'b1; mdead = 1'b1; return;
        end
        mx.push_front(x); my.push_front(y);
        if (g && mlen < mmax) mlen++;
        while (mx.size() > mlen) begin
            void'(mx.pop_back()); void'(my.pop_back());
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; step = 1'b0; grow = 1'b0;
        tick();
        rst = 1'b0;
        mx = {5'd10, 5'd9, 5'd8}; my = {5'd10, 5'd10, 5'd10};
        mlen = 3; mdead = 1'b0; mcol = 1'b0;
        sb.delete();
    endtask

    task automatic drive_step(logic [4:0] x, logic [4:0] y, bit g);
        step = 1'b1; head_x = x; head_y = y; grow = g;
        m_step(x, y, g);
        tick();
        step = 1'b0; grow = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        query_x = 5'd9; query_y = 5'd10; #1;
        n_tests++; if (length !== 6'd3) begin n_fail++; $display("FAIL reset_len got %0d want 3", length); end
        n_tests++; if (game_over !== 1'b0 || collide !== 1'b0) begin n_fail++; $display("FAIL reset_flags got go=%b col=%b want 0 0", game_over, collide); end
        n_tests++; if (rd_valid !== 1'b0 || rd_x !== 5'd0 || rd_y !== 5'd0) begin n_fail++; $display("FAIL reset_rd got v=%b x=%0d y=%0d want 0 0 0", rd_valid, rd_x, rd_y); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
        n_tests++; if (query_hit !== 1'b1 || query_head !== 1'b0) begin n_fail++; $display("FAIL reset_q9 got hit=%b head=%b want 1 0", query_hit, query_head); end
        query_x = 5'd8; #1;
        n_tests++; if (query_hit !== 1'b1) begin n_fail++; $display("FAIL reset_q8 got %b want 1", query_hit); end
        query_x = 5'd7; #1;
        n_tests++; if (query_hit !== 1'b0) begin n_fail++; $display("FAIL reset_q7 got %b want 0", query_hit); end
        query_x = 5'd10; #1;
        n_tests++; if (query_head !== 1'b1) begin n_fail++; $display("FAIL reset_qhead got %b want 1", query_head); end
    endtask

    task automatic test_step_read();
        rd_exp_t e;
        do_reset();
        drive_step(5'd11, 5'd10, 1'b0);
        query_x = 5'd8; query_y = 5'd10; #1;
        n_tests++; if (query_hit !== 1'b0) begin n_fail++; $display("FAIL step_q8 got %b want 0", query_hit); end
        n_tests++; if (length !== 6'd3 || collide !== 1'b0) begin n_fail++; $display("FAIL step_len got len=%0d col=%b want 3 0", length, collide); end
        for (int k = 0; k < 4; k++) begin
            rd_idx = 6'(k);
            sb.push_back('{k < mlen, (k < mlen) ? mx[k] : 5'd0, (k < mlen) ? my[k] : 5'd0});
            tick();
            e = sb.pop_front();
            n_tests++;
            if (rd_valid !== e.v || (e.v && (rd_x !== e.x || rd_y !== e.y))) begin
                n_fail++; $display("FAIL rd_idx%0d got v=%b x=%0d y=%0d want v=%b x=%0d y=%0d", k, rd_valid, rd_x, rd_y, e.v, e.x, e.y);
            end
        end
        rd_idx = 6'd0;
        sb.push_back('{1'b1, mx[0], my[0]});
        drive_step(5'd12, 5'd10, 1'b0);
        e = sb.pop_front();
        n_tests++; if (rd_x !== e.x || rd_valid !== 1'b1) begin n_fail++; $display("FAIL rd_same_edge got x=%0d want %0d", rd_x, e.x); end
        tick();
        n_tests++; if (rd_x !== 5'd12) begin n_fail++; $display("FAIL rd_after_step got x=%0d want 12", rd_x); end
    endtask

    task automatic test_tail_chase();
        do_reset();
        drive_step(5'd11, 5'd10, 1'b1);
        drive_step(5'd8, 5'd10, 1'b0);
        n_tests++; if (collide !== 1'b0 || length !== 6'd4) begin n_fail++; $display("FAIL tail_g0 got col=%b len=%0d want 0 4", collide, length); end
        query_x = 5'd8; query_y = 5'd10; #1;
        n_tests++; if (query_head !== 1'b1) begin n_fail++; $display("FAIL tail_moved got head=%b want 1", query_head); end
        drive_step(5'd9, 5'd10, 1'b1);
        n_tests++; if (collide !== mcol || game_over !== 1'b1) begin n_fail++; $display("FAIL tail_g1 got col=%b go=%b want %b 1", collide, game_over, mcol); end
        tick();
        n_tests++; if (collide !== 1'b0 || game_over !== 1'b1) begin n_fail++; $display("FAIL tail_pulse got col=%b go=%b want 0 1", collide, game_over); end
        n_tests++; if (length !== 6'(mlen) || query_head !== 1'b1) begin n_fail++; $display("FAIL tail_frozen got len=%0d head=%b want %0d 1", length, query_head, mlen); end
    endtask

    task automatic test_full();
        mmax = 4;
        do_reset();
        drive_step(5'd11, 5'd10, 1'b1);
        n_tests++; if (length4 !== 3'd4 || full4 !== 1'b1) begin n_fail++; $display("FAIL full_first got len=%0d full=%b want 4 1", length4, full4); end
        drive_step(5'd12, 5'd10, 1'b1);
        drive_step(5'd13, 5'd10, 1'b1);
        query_x = 5'd10; query_y = 5'd10; #1;
        n_tests++; if (length4 !== 3'(mlen) || full4 !== 1'b1 || collide4 !== 1'b0) begin n_fail++; $display("FAIL full_hold got len=%0d full=%b col=%b want %0d 1 0", length4, full4, collide4, mlen); end
        n_tests++; if (query_hit4 !== m_hit(5'd10, 5'd10)) begin n_fail++; $display("FAIL full_q10 got %b want %b", query_hit4, m_hit(5'd10, 5'd10)); end
        query_x = 5'd13; #1;
        n_tests++; if (query_head4 !== 1'b1) begin n_fail++; $display("FAIL full_head got %b want 1", query_head4); end
        mmax = 32;
    endtask

    task automatic test_reversal();
        do_reset();
        drive_step(5'd11, 5'd10, 1'b0);
        drive_step(5'd10, 5'd10, 1'b0);
        n_tests++; if (collide !== 1'b1 || game_over !== 1'b1) begin n_fail++; $display("FAIL rev_col got col=%b go=%b want 1 1", collide, game_over); end
        drive_step(5'd12, 5'd10, 1'b1);
        query_x = 5'd12; query_y = 5'd10; #1;
        n_tests++; if (query_hit !== 1'b0 || length !== 6'd3 || collide !== 1'b0) begin n_fail++; $display("FAIL rev_ignored got hit=%b len=%0d col=%b want 0 3 0", query_hit, length, collide); end
        query_x = 5'd11; #1;
        n_tests++; if (query_head !== 1'b1 || game_over !== 1'b1) begin n_fail++; $display("FAIL rev_frozen got head=%b go=%b want 1 1", query_head, game_over); end
        do_reset();
        query_x = 5'd8; #1;
        n_tests++; if (game_over !== 1'b0 || query_hit !== 1'b1) begin n_fail++; $display("FAIL rev_reset got go=%b hit=%b want 0 1", game_over, query_hit); end
    endtask

    task automatic test_rst_step();
        do_reset();
        drive_step(5'd11, 5'd10, 1'b1);
        rst = 1'b1; step = 1'b1; head_x = 5'd20; head_y = 5'd20; grow = 1'b1;
        tick();
        rst = 1'b0; step = 1'b0; grow = 1'b0;
        query_x = 5'd20; query_y = 5'd20; #1;
        n_tests++; if (query_hit !== 1'b0 || length !== 6'd3) begin n_fail++; $display("FAIL rst_step got hit=%b len=%0d want 0 3", query_hit, length); end
        query_x = 5'd8; query_y = 5'd10; #1;
        n_tests++; if (query_hit !== 1'b1 || game_over !== 1'b0 || collide !== 1'b0) begin n_fail++; $display("FAIL rst_step_body got hit=%b go=%b col=%b want 1 0 0", query_hit, game_over, collide); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] x, y, qx, qy;
        bit g;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            x = 5'($urandom_range(0, 31)); y = 5'($urandom_range(0, 31));
            g = 1'($urandom_range(0, 1));
            drive_step(x, y, g);
            qx = 5'($urandom_range(0, 31)); qy = 5'($urandom_range(0, 31));
            if (k % 2 == 0) begin qx = mx[mlen-1]; qy = my[mlen-1]; end
            query_x = qx; query_y = qy; #1;
            n_tests++;
            if (collide !== mcol || game_over !== mdead || length !== 6'(mlen) || query_hit !== m_hit(qx, qy)) begin
                n_fail++;
                $display("FAIL b2b_%0d got col=%b go=%b len=%0d hit=%b want %b %b %0d %b", k, collide, game_over, length, query_hit, mcol, mdead, mlen, m_hit(qx, qy));
            end
        end
    endtask

    initial begin
        rst = 1'b1; step = 1'b0; grow = 1'b0;
        head_x = '0; head_y = '0; query_x = '0; query_y = '0;
        rd_idx = '0; rd_idx4 = '0;
        test_reset();
        test_step_read();
        test_tail_chase();
        test_full();
        test_reversal();
        test_rst_step();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
